// File: rtl/tiro_uc.sv
// tiro_uc: control unit for the shot datapath.
// On every game tick it sweeps all shot slots, moving each loaded shot one
// step in its direction or retiring it when it already sits on the border.
// It then services a pending fire request by copying the ship position
// into the first free slot, or reports the shot as lost when all are full.
// The slot counter, memories and adder live in the datapath; this block
// only sequences them and reads back their status flags.

module tiro_uc #(
    parameter int N_SLOTS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       atirar,
    input  logic       loaded,
    input  logic [1:0] opcode,
    input  logic       x_borda_min,
    input  logic       x_borda_max,
    input  logic       y_borda_min,
    input  logic       y_borda_max,
    input  logic       rco_contador,
    output logic       conta_contador,
    output logic       reset_cont,
    output logic [1:0] select_mux_pos,
    output logic       select_mux_coor,
    output logic       select_soma_sub,
    output logic       enable_mem_aste,
    output logic       enable_mem_load,
    output logic       new_load,
    output logic       pronto,
    output logic       tiro_perdido,
    output logic [3:0] db_estado
);

    // Sweep length is set by the datapath counter (rco_contador); the
    // parameter only documents the slot count the counter must match.
    logic unused_n_slots;
    assign unused_n_slots = (N_SLOTS == 16);

    typedef enum logic [3:0] {
        LIMPA_ZERA = 4'd0,
        LIMPA      = 4'd1,
        ESPERA     = 4'd2,
        ZERA       = 4'd3,
        AVALIA     = 4'd4,
        MOVE       = 4'd5,
        DESCARREGA = 4'd6,
        PROXIMO    = 4'd7,
        ZERA_B     = 4'd8,
        BUSCA      = 4'd9,
        CARREGA    = 4'd10,
        PERDIDO    = 4'd11,
        FIM        = 4'd12
    } state_t;

    // Shot direction codes as stored in the position memory.
    localparam logic [1:0] OP_Y_DEC = 2'b00;
    localparam logic [1:0] OP_X_INC = 2'b01;
    localparam logic [1:0] OP_Y_INC = 2'b10;
    localparam logic [1:0] OP_X_DEC = 2'b11;

    // Position mux selections.
    localparam logic [1:0] POS_KEEP = 2'b00;
    localparam logic [1:0] POS_X    = 2'b01;
    localparam logic [1:0] POS_Y    = 2'b10;
    localparam logic [1:0] POS_SHIP = 2'b11;

    state_t     state_q, state_d;
    logic       pendente_q, pendente_d;

    logic       reset_cont_q, reset_cont_d;
    logic [1:0] mux_pos_q, mux_pos_d;
    logic       mux_coor_q, mux_coor_d;
    logic       soma_sub_q, soma_sub_d;
    logic       en_aste_q, en_aste_d;
    logic       en_load_q, en_load_d;
    logic       new_load_q, new_load_d;
    logic       pronto_q, pronto_d;
    logic       perdido_q, perdido_d;

    logic       na_borda;

    // The addressed shot already touches the border it is heading towards.
    always_comb begin
        na_borda = 1'b0;
        case (opcode)
            OP_Y_DEC: na_borda = y_borda_min;
            OP_X_INC: na_borda = x_borda_max;
            OP_Y_INC: na_borda = y_borda_max;
            OP_X_DEC: na_borda = x_borda_min;
            default:  na_borda = 1'b0;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LIMPA_ZERA: state_d = LIMPA;
            LIMPA: begin
                if (rco_contador) begin
                    state_d = ESPERA;
                end
            end
            ESPERA: begin
                // A tick wins; a fire request that came with it is served
                // once the sweep is over.
                if (tick) begin
                    state_d = ZERA;
                end else if (pendente_q) begin
                    state_d = ZERA_B;
                end
            end
            ZERA: state_d = AVALIA;
            AVALIA: begin
                if (!loaded) begin
                    state_d = PROXIMO;
                end else if (na_borda) begin
                    state_d = DESCARREGA;
                end else begin
                    state_d = MOVE;
                end
            end
            MOVE:       state_d = PROXIMO;
            DESCARREGA: state_d = PROXIMO;
            PROXIMO: begin
                if (rco_contador) begin
                    state_d = pendente_q ? ZERA_B : FIM;
                end else begin
                    state_d = AVALIA;
                end
            end
            ZERA_B: state_d = BUSCA;
            BUSCA: begin
                if (!loaded) begin
                    state_d = CARREGA;
                end else if (rco_contador) begin
                    state_d = PERDIDO;
                end
            end
            CARREGA: state_d = FIM;
            PERDIDO: state_d = FIM;
            FIM:     state_d = ESPERA;
            default: state_d = LIMPA_ZERA;
        endcase
    end

    // Fire requests are remembered in any state and collapse into one; the
    // flag drops when the request is finally served or dropped. A new
    // request in that same cycle is kept for the next service.
    always_comb begin
        pendente_d = atirar |
                     (pendente_q & (state_d != CARREGA) & (state_d != PERDIDO));
    end

    // Moore outputs for the state being entered, so they are registered and
    // line up with db_estado. MOVE uses the opcode seen in AVALIA, which is
    // the same slot because the counter does not advance between the two.
    always_comb begin
        reset_cont_d = 1'b0;
        mux_pos_d    = POS_KEEP;
        mux_coor_d   = 1'b0;
        soma_sub_d   = 1'b0;
        en_aste_d    = 1'b0;
        en_load_d    = 1'b0;
        new_load_d   = 1'b0;
        pronto_d     = 1'b0;
        perdido_d    = 1'b0;
        case (state_d)
            LIMPA_ZERA, ZERA, ZERA_B: reset_cont_d = 1'b1;
            LIMPA, DESCARREGA: begin
                en_load_d  = 1'b1;
                new_load_d = 1'b0;
            end
            MOVE: begin
                en_aste_d = 1'b1;
                case (opcode)
                    OP_Y_DEC: begin
                        mux_coor_d = 1'b1;
                        soma_sub_d = 1'b1;
                        mux_pos_d  = POS_Y;
                    end
                    OP_X_INC: begin
                        mux_coor_d = 1'b0;
                        soma_sub_d = 1'b0;
                        mux_pos_d  = POS_X;
                    end
                    OP_Y_INC: begin
                        mux_coor_d = 1'b1;
                        soma_sub_d = 1'b0;
                        mux_pos_d  = POS_Y;
                    end
                    default: begin
                        mux_coor_d = 1'b0;
                        soma_sub_d = 1'b1;
                        mux_pos_d  = POS_X;
                    end
                endcase
            end
            CARREGA: begin
                mux_pos_d  = POS_SHIP;
                en_aste_d  = 1'b1;
                en_load_d  = 1'b1;
                new_load_d = 1'b1;
            end
            PERDIDO: perdido_d = 1'b1;
            FIM:     pronto_d  = 1'b1;
            default: ;
        endcase
    end

    // State, pending-fire flag and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= LIMPA_ZERA;
            pendente_q   <= 1'b0;
            reset_cont_q <= 1'b0;
            mux_pos_q    <= POS_KEEP;
            mux_coor_q   <= 1'b0;
            soma_sub_q   <= 1'b0;
            en_aste_q    <= 1'b0;
            en_load_q    <= 1'b0;
            new_load_q   <= 1'b0;
            pronto_q     <= 1'b0;
            perdido_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pendente_q   <= pendente_d;
            reset_cont_q <= reset_cont_d;
            mux_pos_q    <= mux_pos_d;
            mux_coor_q   <= mux_coor_d;
            soma_sub_q   <= soma_sub_d;
            en_aste_q    <= en_aste_d;
            en_load_q    <= en_load_d;
            new_load_q   <= new_load_d;
            pronto_q     <= pronto_d;
            perdido_q    <= perdido_d;
        end
    end

    // Counter advance has to react to the slot just read, so it stays
    // combinational: step through LIMPA and PROXIMO until the last slot,
    // and keep searching in BUSCA while the addressed slot is occupied.
    always_comb begin
        conta_contador = 1'b0;
        case (state_q)
            LIMPA:   conta_contador = !rco_contador;
            PROXIMO: conta_contador = !rco_contador;
            BUSCA:   conta_contador = loaded & !rco_contador;
            default: conta_contador = 1'b0;
        endcase
    end

    assign reset_cont      = reset_cont_q;
    assign select_mux_pos  = mux_pos_q;
    assign select_mux_coor = mux_coor_q;
    assign select_soma_sub = soma_sub_q;
    assign enable_mem_aste = en_aste_q;
    assign enable_mem_load = en_load_q;
    assign new_load        = new_load_q;
    assign pronto          = pronto_q;
    assign tiro_perdido    = perdido_q;
    assign db_estado       = state_q;

endmodule
